// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: signal bundle between the decoder/register file (ID side),
// the ID/EX pipeline register and the EX stage.
// master: the pipeline environment (decoder, hazard consumers, EX stage).
// slave:  the id_ex_stage block itself.
interface id_ex_stage_if;
    logic [31:0] id_instruction;
    logic        id_reg_write;
    logic        id_mem_to_reg_write;
    logic        id_mem_read;
    logic        id_mem_write;
    logic        id_branch;
    logic        id_alu_source;
    logic        id_alu_source_shift;
    logic        id_reg_dst;
    logic [3:0]  id_alu_control;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic [31:0] id_pc_plus4;
    logic        branch_flush;
    logic        control_mux;
    logic        if_id_stall;
    logic        ex_reg_write;
    logic        ex_mem_to_reg_write;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_branch;
    logic        ex_alu_source;
    logic        ex_alu_source_shift;
    logic [3:0]  ex_alu_control;
    logic [31:0] ex_rs_data;
    logic [31:0] ex_rt_data;
    logic [31:0] ex_imm;
    logic [31:0] ex_pc_plus4;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_write_reg;
    logic [4:0]  ex_shamt;

    modport master (
        output id_instruction, id_reg_write, id_mem_to_reg_write, id_mem_read,
               id_mem_write, id_branch, id_alu_source, id_alu_source_shift,
               id_reg_dst, id_alu_control, id_rs_data, id_rt_data, id_pc_plus4,
               branch_flush,
        input  control_mux, if_id_stall,
               ex_reg_write, ex_mem_to_reg_write, ex_mem_read, ex_mem_write,
               ex_branch, ex_alu_source, ex_alu_source_shift, ex_alu_control,
               ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus4,
               ex_rs, ex_rt, ex_write_reg, ex_shamt
    );

    modport slave (
        input  id_instruction, id_reg_write, id_mem_to_reg_write, id_mem_read,
               id_mem_write, id_branch, id_alu_source, id_alu_source_shift,
               id_reg_dst, id_alu_control, id_rs_data, id_rt_data, id_pc_plus4,
               branch_flush,
        output control_mux, if_id_stall,
               ex_reg_write, ex_mem_to_reg_write, ex_mem_read, ex_mem_write,
               ex_branch, ex_alu_source, ex_alu_source_shift, ex_alu_control,
               ex_rs_data, ex_rt_data, ex_imm, ex_pc_plus4,
               ex_rs, ex_rt, ex_write_reg, ex_shamt
    );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the five-stage MIPS pipeline with
// read-after-write hazard detection, branch-flush bubbles and a saturating
// hazard-bubble counter.
// Build option: define ID_EX_FORWARD_EN when an EX forwarding unit exists;
// only load-use hazards then stall. Otherwise EX and MEM producers both stall.
module id_ex_stage #(
    parameter int BUBBLE_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    id_ex_stage_if.slave            bus,
    output logic [BUBBLE_CNT_W-1:0] bubble_count
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [BUBBLE_CNT_W-1:0] CNT_MAX = {BUBBLE_CNT_W{1'b1}};
    localparam logic [BUBBLE_CNT_W-1:0] CNT_ONE = BUBBLE_CNT_W'(1'b1);

    typedef struct packed {
        logic        reg_write;
        logic        mem_to_reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        alu_source;
        logic        alu_source_shift;
        logic [3:0]  alu_control;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [31:0] pc_plus4;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  write_reg;
        logic [4:0]  shamt;
    } ex_bundle_t;

    // Shifts by immediate (sll/srl/sra) ignore the rs field.
    function automatic logic rs_used(input logic [31:0] instr);
        logic used;
        if (instr[31:26] == OP_RTYPE) begin
            case (instr[5:0])
                6'h00, 6'h02, 6'h03: used = 1'b0;
                default:             used = 1'b1;
            endcase
        end else begin
            used = 1'b1;
        end
        return used;
    endfunction

    // R-type, branches and stores read rt as a source.
    function automatic logic rt_used(input logic [31:0] instr);
        logic used;
        case (instr[31:26])
            OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: used = 1'b1;
            default:                         used = 1'b0;
        endcase
        return used;
    endfunction

    // Logical immediates are zero-extended, everything else sign-extended.
    function automatic logic [31:0] imm_ext(input logic [31:0] instr);
        logic [31:0] imm;
        case (instr[31:26])
            OP_ANDI, OP_ORI, OP_XORI: imm = {16'h0000, instr[15:0]};
            default:                  imm = {{16{instr[15]}}, instr[15:0]};
        endcase
        return imm;
    endfunction

    // A used, nonzero source register equal to a tracked destination.
    function automatic logic reg_match(input logic [31:0] instr, input logic [4:0] dst);
        logic rs_hit;
        logic rt_hit;
        rs_hit = rs_used(instr) && (instr[25:21] != 5'd0) && (instr[25:21] == dst);
        rt_hit = rt_used(instr) && (instr[20:16] != 5'd0) && (instr[20:16] == dst);
        return rs_hit | rt_hit;
    endfunction

    ex_bundle_t              ex_r;
    ex_bundle_t              ex_next_s;
    logic                    mem_reg_write_r;
    logic [4:0]              mem_write_reg_r;
    logic [BUBBLE_CNT_W-1:0] bubble_count_r;
    logic                    hazard_s;
    logic                    control_mux_s;
    logic                    if_id_stall_s;
    logic                    count_bubble_s;

    // Hazard detection against tracked producers; decoded from the raw
    // instruction so it never depends on control_mux.
    always_comb begin
`ifdef ID_EX_FORWARD_EN
        hazard_s = ex_r.mem_read & ex_r.reg_write
                 & reg_match(bus.id_instruction, ex_r.write_reg);
`else
        hazard_s = (ex_r.reg_write & reg_match(bus.id_instruction, ex_r.write_reg))
                 | (mem_reg_write_r & reg_match(bus.id_instruction, mem_write_reg_r));
`endif
    end

    // Stall/squash decision: reset and flush both override a hazard.
    always_comb begin
        control_mux_s  = 1'b1;
        if_id_stall_s  = 1'b0;
        count_bubble_s = 1'b0;
        if (reset) begin
            control_mux_s  = 1'b1;
            if_id_stall_s  = 1'b0;
            count_bubble_s = 1'b0;
        end else if (bus.branch_flush) begin
            control_mux_s  = 1'b1;
            if_id_stall_s  = 1'b0;
            count_bubble_s = 1'b0;
        end else if (hazard_s) begin
            control_mux_s  = 1'b0;
            if_id_stall_s  = 1'b1;
            count_bubble_s = 1'b1;
        end else begin
            control_mux_s  = 1'b1;
            if_id_stall_s  = 1'b0;
            count_bubble_s = 1'b0;
        end
    end

    // Next EX contents: a bubble on flush or hazard, else the ID instruction.
    always_comb begin
        ex_next_s = '0;
        if (bus.branch_flush || hazard_s) begin
            ex_next_s = '0;
        end else begin
            ex_next_s.reg_write        = bus.id_reg_write;
            ex_next_s.mem_to_reg_write = bus.id_mem_to_reg_write;
            ex_next_s.mem_read         = bus.id_mem_read;
            ex_next_s.mem_write        = bus.id_mem_write;
            ex_next_s.branch           = bus.id_branch;
            ex_next_s.alu_source       = bus.id_alu_source;
            ex_next_s.alu_source_shift = bus.id_alu_source_shift;
            ex_next_s.alu_control      = bus.id_alu_control;
            ex_next_s.rs_data          = bus.id_rs_data;
            ex_next_s.rt_data          = bus.id_rt_data;
            ex_next_s.imm              = imm_ext(bus.id_instruction);
            ex_next_s.pc_plus4         = bus.id_pc_plus4;
            ex_next_s.rs               = bus.id_instruction[25:21];
            ex_next_s.rt               = bus.id_instruction[20:16];
            ex_next_s.write_reg        = bus.id_reg_dst ? bus.id_instruction[15:11]
                                                        : bus.id_instruction[20:16];
            ex_next_s.shamt            = bus.id_instruction[10:6];
        end
    end

    // Pipeline register, MEM destination shadow and saturating bubble counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_r            <= '0;
            mem_reg_write_r <= 1'b0;
            mem_write_reg_r <= 5'd0;
            bubble_count_r  <= '0;
        end else begin
            ex_r            <= ex_next_s;
            mem_reg_write_r <= ex_r.reg_write;
            mem_write_reg_r <= ex_r.write_reg;
            if (count_bubble_s && (bubble_count_r != CNT_MAX)) begin
                bubble_count_r <= bubble_count_r + CNT_ONE;
            end else begin
                bubble_count_r <= bubble_count_r;
            end
        end
    end

    assign bus.control_mux         = control_mux_s;
    assign bus.if_id_stall         = if_id_stall_s;
    assign bus.ex_reg_write        = ex_r.reg_write;
    assign bus.ex_mem_to_reg_write = ex_r.mem_to_reg_write;
    assign bus.ex_mem_read         = ex_r.mem_read;
    assign bus.ex_mem_write        = ex_r.mem_write;
    assign bus.ex_branch           = ex_r.branch;
    assign bus.ex_alu_source       = ex_r.alu_source;
    assign bus.ex_alu_source_shift = ex_r.alu_source_shift;
    assign bus.ex_alu_control      = ex_r.alu_control;
    assign bus.ex_rs_data          = ex_r.rs_data;
    assign bus.ex_rt_data          = ex_r.rt_data;
    assign bus.ex_imm              = ex_r.imm;
    assign bus.ex_pc_plus4         = ex_r.pc_plus4;
    assign bus.ex_rs               = ex_r.rs;
    assign bus.ex_rt               = ex_r.rt;
    assign bus.ex_write_reg        = ex_r.write_reg;
    assign bus.ex_shamt            = ex_r.shamt;
    assign bubble_count            = bubble_count_r;
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage for the five-stage MIPS pipeline. Sits directly downstream of the instruction decoder. It registers the decoder's control bits, the register operands and the immediate fields into the EX stage. It also detects read-after-write hazards, driving the decoder's `control_mux` low to squash the instruction in ID into a bubble and stalling PC/IF-ID. It inserts flush bubbles on taken branches and counts hazard bubbles.

## Interface
Parameters:
- `BUBBLE_CNT_W`, default 16: width of the hazard-bubble counter.

Ports:
- `clk`  in  1: sole clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `id_instruction`  in  32: instruction currently in ID.
- `id_reg_write`, `id_mem_to_reg_write`, `id_mem_read`, `id_mem_write`, `id_branch`, `id_alu_source`, `id_alu_source_shift`, `id_reg_dst`  in  1 each: decoder outputs.
- `id_alu_control`  in  4: decoder ALU op.
- `id_rs_data`, `id_rt_data`  in  32: register-file read data.
- `id_pc_plus4`  in  32: PC+4 of the ID instruction.
- `branch_flush`  in  1: taken branch resolved in EX.
- `control_mux`  out  1: to decoder; 0 forces all decoder outputs to zero.
- `if_id_stall`  out  1: hold PC and IF/ID register.
- `ex_reg_write`, `ex_mem_to_reg_write`, `ex_mem_read`, `ex_mem_write`, `ex_branch`, `ex_alu_source`, `ex_alu_source_shift`  out  1 each: registered controls.
- `ex_alu_control`  out  4.
- `ex_rs_data`, `ex_rt_data`, `ex_imm`, `ex_pc_plus4`  out  32.
- `ex_rs`, `ex_rt`, `ex_write_reg`, `ex_shamt`  out  5.
- `bubble_count`  out  `BUBBLE_CNT_W`: hazard bubbles inserted, saturating.

## Operation
- **Source-use decode:** taken from `id_instruction` only, never from `id_*` controls, to avoid a loop through `control_mux`.
  - rs is used unless opcode=0 and funct∈{0x00,0x02,0x03}.
  - rt is used when opcode∈{0x00,0x04,0x05,0x2B}.
- **Destination:** `write_reg` = `id_reg_dst` ? instr[15:11] : instr[20:16].
- **Immediate:** instr[15:0] is zero-extended for opcodes 0x0C/0x0D/0x0E and sign-extended otherwise.
  - `ex_shamt` = instr[10:6].
  - `ex_rs` = instr[25:21].
  - `ex_rt` = instr[20:16].
- **MEM shadow:** internal `mem_reg_write` and `mem_write_reg`, loaded each cycle from the current EX-stage values.
- **Match:** a source register is used, is nonzero, and equals the tracked destination. Register $0 never matches.
- **Hazard:** computed per the Configuration section. While `hazard`=1 and `branch_flush`=0:
  - `control_mux`=0 and `if_id_stall`=1, combinationally.
  - At the next edge the EX register loads a bubble and `bubble_count` increments, saturating at all-ones.
- **Bubble:** all `ex_*` outputs zero.
- **Flush:** `branch_flush`=1 has priority over `hazard`.
  - EX loads a bubble.
  - `if_id_stall`=0 and `control_mux`=1.
  - Not counted in `bubble_count`.
- **Normal:** the EX register loads all `id_*` values and the derived fields.
- **Reset:**
  - All `ex_*` outputs, the MEM shadow and `bubble_count` are 0.
  - While `reset`=1, `control_mux`=1 and `if_id_stall`=0 are forced.

## Timing
- Latency is 1 cycle from ID inputs to `ex_*` outputs.
- `control_mux` and `if_id_stall` are combinational from `id_instruction`, EX state and MEM shadow, valid in the same cycle.
- A load-use hazard costs 1 bubble.
- Without forwarding, an ALU result costs 2 bubbles if the producer is adjacent, or 1 if one instruction separates them.
- The register file writes in the first half-cycle and reads in the second, so WB needs no tracking.
- Reset asserted mid-stall: the next edge clears everything and the stall drops in the reset cycle.
- Flush and hazard in the same cycle: flush behaviour only.

## Configuration
`ID_EX_FORWARD_EN`:
- **Defined:** `hazard` = `ex_mem_read` & `ex_reg_write` & match(`ex_write_reg`). This covers load-use only; the EX forwarding unit covers the rest.
- **Undefined:** `hazard` = (`ex_reg_write` & match(`ex_write_reg`)) | (`mem_reg_write` & match(`mem_write_reg`)).

## Test plan
- `ID_EX_FORWARD_EN` defined; lw $9 in EX, ID=add $10,$9,$11 → one cycle `control_mux`=0 and `if_id_stall`=1; next edge all `ex_*`=0; following edge `ex_write_reg`=10; `bubble_count`=1.
- `ID_EX_FORWARD_EN` undefined; addi $8,$0,5 then add $9,$8,$8 back-to-back → two stall cycles, then add enters EX; `bubble_count`=2.
- lw $4 in EX, ID=sll $3,$5,2 with rs field=4 → no stall. lw $0 in EX, ID uses $0 → no stall.
- Hazard and `branch_flush`=1 in the same cycle → `if_id_stall`=0, EX bubble, `bubble_count` unchanged.
- ori $2,$0,0x8000 → `ex_imm`=0x00008000. addi $2,$0,0x8000 → `ex_imm`=0xFFFF8000.
- `reset` pulsed during a stall → next cycle all `ex_*`=0, `bubble_count`=0, `control_mux`=1.
